// File: rtl/fp_issue_arbiter.sv
// ---------------------------------------------------------------------------
// fp_issue_arbiter
//
// Picks one requesting hardware thread per cycle, round-robin, for issue into
// the shared execute back end. The integer pipe writes back one cycle after
// issue and the float pipe writes back FP_LATENCY cycles after issue. Both
// share a single writeback port. A small reservation vector tracks which
// upcoming writeback slots already belong to in-flight float instructions,
// so an integer issue is held back when it would collide with a float result.
// Rollbacks drop the reservations owned by the squashed thread.
//
// Optional feature (macro FP_ISSUE_STARVATION_GUARD_EN):
//   Per-thread counters of integer denials caused by a reserved slot. Once a
//   counter reaches STARVE_LIMIT, float requests from every thread are held
//   off so the reservations drain and the starved integer request can issue.
//   Without the macro there are no counters and floats are never held off.
//
// Ports:
//   clk                     the only clock
//   reset                   asynchronous, active-high
//   ts_req_valid[N]         per-thread issue request
//   ts_req_long[N]          per-thread pipe select (1 = float, 0 = integer)
//   wb_rollback_en          rollback in progress
//   wb_rollback_thread_idx  thread being rolled back
//   ia_grant_valid          an issue occurs this cycle
//   ia_grant_oh[N]          one-hot grant, or zero
//   ia_grant_thread_idx     encoded granted thread (zero when no grant)
//   ia_grant_long           granted instruction goes to the float pipe
//   ia_wb_reserved          reservation vector occ[FP_LATENCY-1:1]
//
// Timing frame: in any cycle, occ[i] means writeback slot (g + i) is taken,
// where g is the issue cycle of the decision being made in this cycle.
// ---------------------------------------------------------------------------
module fp_issue_arbiter #(
  parameter int NUM_THREADS  = 4,
  parameter int FP_LATENCY   = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         ts_req_valid,
  input  logic [NUM_THREADS-1:0]         ts_req_long,
  input  logic                           wb_rollback_en,
  input  logic [$clog2(NUM_THREADS)-1:0] wb_rollback_thread_idx,
  output logic                           ia_grant_valid,
  output logic [NUM_THREADS-1:0]         ia_grant_oh,
  output logic [$clog2(NUM_THREADS)-1:0] ia_grant_thread_idx,
  output logic                           ia_grant_long,
  output logic [FP_LATENCY-2:0]          ia_wb_reserved
);

  localparam int TW = $clog2(NUM_THREADS);
  typedef logic [TW-1:0] local_thread_idx_t;

  if (FP_LATENCY < 3 || FP_LATENCY > 8 || NUM_THREADS < 2 || STARVE_LIMIT < 1) begin : g_param_check
    $error("fp_issue_arbiter: illegal parameter combination");
  end

  // Decisions are suppressed for the first cycle after reset release, so the
  // earliest grant lands on the second rising edge after deassertion.
  logic armed;

  local_thread_idx_t rr_ptr;
  local_thread_idx_t rr_ptr_next;
  local_thread_idx_t pick_idx;
  local_thread_idx_t cand;
  logic              pick_found;
  logic              pick_long;
  logic              fp_block;

  logic [NUM_THREADS-1:0] rb_kill;
  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] pick_oh;

  // Owner index is only kept from slot 2 upward: slot 1 is consumed by the
  // current decision and shifts out on the next edge, so its owner is never
  // needed again.
  logic [FP_LATENCY-1:1]         occ_valid;
  logic [FP_LATENCY-1:1]         occ_valid_next;
  logic [FP_LATENCY-1:2][TW-1:0] occ_tid;
  logic [FP_LATENCY-1:2][TW-1:0] occ_tid_next;

  // Eligibility. Float requests ignore reservations: one grant per cycle
  // means two floats can never target the same writeback slot.
  always_comb begin
    rb_kill  = '0;
    eligible = '0;
    for (int n = 0; n < NUM_THREADS; n++) begin
      rb_kill[n] = wb_rollback_en && (wb_rollback_thread_idx == local_thread_idx_t'(n));
      if (ts_req_long[n]) begin
        eligible[n] = armed && ts_req_valid[n] && !rb_kill[n] && !fp_block;
      end else begin
        eligible[n] = armed && ts_req_valid[n] && !rb_kill[n] && !occ_valid[1];
      end
    end
  end

  // Round-robin search starting at rr_ptr, ascending with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      cand = local_thread_idx_t'((int'(rr_ptr) + k) % NUM_THREADS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_long = pick_found && ts_req_long[pick_idx];
    if (!pick_found) begin
      rr_ptr_next = rr_ptr;
    end else if (pick_idx == local_thread_idx_t'(NUM_THREADS - 1)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = pick_idx + 1'b1;
    end
  end

  always_comb begin
    pick_oh = '0;
    for (int n = 0; n < NUM_THREADS; n++) begin
      pick_oh[n] = pick_found && (pick_idx == local_thread_idx_t'(n));
    end
  end

  // Reservation update: shift down one slot, append the new float grant at
  // the top, and clear anything owned by the rolled-back thread in the
  // shifted copy so nothing survives a cycle past its rollback.
  always_comb begin
    occ_valid_next = '0;
    occ_tid_next   = '0;
    for (int i = 1; i < FP_LATENCY - 1; i++) begin
      occ_valid_next[i] = occ_valid[i+1] &&
                          !(wb_rollback_en && (occ_tid[i+1] == wb_rollback_thread_idx));
    end
    for (int i = 2; i < FP_LATENCY - 1; i++) begin
      occ_tid_next[i] = occ_tid[i+1];
    end
    occ_valid_next[FP_LATENCY-1] = pick_long && !rb_kill[pick_idx];
    occ_tid_next[FP_LATENCY-1]   = pick_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed               <= 1'b0;
      rr_ptr              <= '0;
      occ_valid           <= '0;
      occ_tid             <= '0;
      ia_grant_valid      <= 1'b0;
      ia_grant_oh         <= '0;
      ia_grant_thread_idx <= '0;
      ia_grant_long       <= 1'b0;
    end else begin
      armed               <= 1'b1;
      rr_ptr              <= rr_ptr_next;
      occ_valid           <= occ_valid_next;
      occ_tid             <= occ_tid_next;
      ia_grant_valid      <= pick_found;
      ia_grant_oh         <= pick_oh;
      ia_grant_thread_idx <= pick_idx;
      ia_grant_long       <= pick_long;
    end
  end

  assign ia_wb_reserved = occ_valid;

`ifdef FP_ISSUE_STARVATION_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_THREADS-1:0][CW-1:0] starve_cnt;
  logic [NUM_THREADS-1:0][CW-1:0] starve_cnt_next;

  always_comb begin
    fp_block = 1'b0;
    for (int n = 0; n < NUM_THREADS; n++) begin
      if (starve_cnt[n] >= CW'(STARVE_LIMIT)) begin
        fp_block = 1'b1;
      end
    end
  end

  // Counts only denials caused by a reserved slot; losing round-robin or
  // being rolled back leaves the count alone. Cleared by a grant or by the
  // integer request going away.
  always_comb begin
    starve_cnt_next = starve_cnt;
    for (int n = 0; n < NUM_THREADS; n++) begin
      if (!(ts_req_valid[n] && !ts_req_long[n]) || pick_oh[n]) begin
        starve_cnt_next[n] = '0;
      end else if (occ_valid[1] && !rb_kill[n] && (starve_cnt[n] < CW'(STARVE_LIMIT))) begin
        starve_cnt_next[n] = starve_cnt[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end
`else
  assign fp_block = 1'b0;
`endif

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_issue_arbiter
//
// Directed scenarios plus a random run. A reference model keeps reservations
// as absolute writeback cycle numbers; at every rising edge it predicts the
// registered grant and the reservation vector for the new cycle and queues
// the prediction. A monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_fp_issue_arbiter;

  localparam int N     = 4;
  localparam int L     = 5;
  localparam int LIMIT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_v = '0;
  logic [3:0] req_l = '0;
  logic       rb_en = 1'b0;
  logic [1:0] rb_idx = '0;

  logic       ia_grant_valid;
  logic [3:0] ia_grant_oh;
  logic [1:0] ia_grant_thread_idx;
  logic       ia_grant_long;
  logic [3:0] ia_wb_reserved;

  int checks = 0;
  int failures = 0;

  fp_issue_arbiter #(
    .NUM_THREADS (N),
    .FP_LATENCY  (L),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ts_req_valid          (req_v),
    .ts_req_long           (req_l),
    .wb_rollback_en        (rb_en),
    .wb_rollback_thread_idx(rb_idx),
    .ia_grant_valid        (ia_grant_valid),
    .ia_grant_oh           (ia_grant_oh),
    .ia_grant_thread_idx   (ia_grant_thread_idx),
    .ia_grant_long         (ia_grant_long),
    .ia_wb_reserved        (ia_wb_reserved)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] oh;
    logic [1:0] idx;
    logic       lng;
    logic [3:0] res;
  } exp_t;

  exp_t sbq[$];

  // ---------------- reference model ----------------
  int   m_cyc;
  bit   m_armed;
  int   m_rr;
  int   m_slot[int];
  int   m_keys[$];
  int   m_cnt[N];
  int   m_win;
  int   m_n;
  bit   m_blk;
  bit   m_busy;
  exp_t m_e;

  always @(posedge clk) begin
    if (reset) begin
      m_cyc   = 0;
      m_armed = 0;
      m_rr    = 0;
      m_slot.delete();
      sbq.delete();
      for (int n = 0; n < N; n++) m_cnt[n] = 0;
    end else begin
      m_cyc++;
      m_e = '0;
      if (m_armed) begin
        m_blk = 0;
`ifdef FP_ISSUE_STARVATION_GUARD_EN
        for (int n = 0; n < N; n++) if (m_cnt[n] >= LIMIT) m_blk = 1;
`endif
        // Decision was made in cycle m_cyc-1; its integer result would write
        // back in m_cyc+1.
        m_busy = m_slot.exists(m_cyc + 1);
        m_win = -1;
        for (int k = 0; k < N; k++) begin
          m_n = (m_rr + k) % N;
          if (m_win < 0 && req_v[m_n] && !(rb_en && rb_idx == m_n)) begin
            if (req_l[m_n] ? !m_blk : !m_busy) m_win = m_n;
          end
        end
`ifdef FP_ISSUE_STARVATION_GUARD_EN
        for (int n = 0; n < N; n++) begin
          if (!(req_v[n] && !req_l[n]) || m_win == n) m_cnt[n] = 0;
          else if (m_busy && !(rb_en && rb_idx == n) && m_cnt[n] < LIMIT) m_cnt[n]++;
        end
`endif
        if (rb_en) begin
          m_keys = {};
          foreach (m_slot[s]) if (s >= m_cyc + 2 && m_slot[s] == int'(rb_idx)) m_keys.push_back(s);
          foreach (m_keys[j]) m_slot.delete(m_keys[j]);
        end
        if (m_win >= 0) begin
          m_e.v   = 1'b1;
          m_e.oh  = 4'b0001 << m_win;
          m_e.idx = 2'(m_win);
          m_e.lng = req_l[m_win];
          m_rr    = (m_win + 1) % N;
          if (req_l[m_win]) m_slot[m_cyc + L] = m_win;
        end
      end
      for (int i = 1; i < L; i++) m_e.res[i-1] = m_slot.exists(m_cyc + 1 + i);
      m_armed = 1;
      sbq.push_back(m_e);
    end
  end

  // ---------------- scoreboard monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
    end else if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if ({ia_grant_valid, ia_grant_oh, ia_grant_thread_idx, ia_grant_long, ia_wb_reserved} !== mon_e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got v=%b oh=%b idx=%0d long=%b res=%b, expected v=%b oh=%b idx=%0d long=%b res=%b",
                 $time, ia_grant_valid, ia_grant_oh, ia_grant_thread_idx, ia_grant_long, ia_wb_reserved,
                 mon_e.v, mon_e.oh, mon_e.idx, mon_e.lng, mon_e.res);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset  = 1'b1;
    req_v  = '0;
    req_l  = '0;
    rb_en  = 1'b0;
    rb_idx = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (ia_grant_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b expected=0", ia_grant_valid); end
    checks++;
    if (ia_grant_oh !== 4'b0000) begin failures++; $display("FAIL reset_oh got=%b expected=0000", ia_grant_oh); end
    checks++;
    if (ia_grant_thread_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d expected=0", ia_grant_thread_idx); end
    checks++;
    if (ia_grant_long !== 1'b0) begin failures++; $display("FAIL reset_long got=%b expected=0", ia_grant_long); end
    checks++;
    if (ia_wb_reserved !== 4'b0000) begin failures++; $display("FAIL reset_reserved got=%b expected=0000", ia_wb_reserved); end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_single_int();
    do_reset();
    req_v = 4'b0001;
    req_l = 4'b0000;
    tick();
    checks++;
    if (ia_grant_valid !== 1'b0) begin failures++; $display("FAIL first_edge_no_grant got=%b expected=0", ia_grant_valid); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ia_grant_oh !== 4'b0001 || ia_grant_long !== 1'b0) begin
        failures++;
        $display("FAIL single_int_grant got oh=%b long=%b expected oh=0001 long=0", ia_grant_oh, ia_grant_long);
      end
    end
    req_v = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_v = 4'b1111;
    req_l = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ia_grant_valid !== 1'b1 || ia_grant_thread_idx !== 2'(k % 4)) begin
        failures++;
        $display("FAIL round_robin step=%0d got v=%b idx=%0d expected v=1 idx=%0d",
                 k, ia_grant_valid, ia_grant_thread_idx, k % 4);
      end
    end
    req_v = '0;
  endtask

  task automatic test_fp_reserve();
    do_reset();
    req_v = 4'b0010;
    req_l = 4'b0010;
    tick();
    tick();
    checks++;
    if (ia_grant_thread_idx !== 2'd1 || ia_grant_long !== 1'b1 || ia_wb_reserved !== 4'b1000) begin
      failures++;
      $display("FAIL fp_grant got idx=%0d long=%b res=%b expected idx=1 long=1 res=1000",
               ia_grant_thread_idx, ia_grant_long, ia_wb_reserved);
    end
    req_v = '0;
    req_l = '0;
    tick();
    checks++;
    if (ia_wb_reserved !== 4'b0100) begin failures++; $display("FAIL fp_shift1 got=%b expected=0100", ia_wb_reserved); end
    tick();
    checks++;
    if (ia_wb_reserved !== 4'b0010) begin failures++; $display("FAIL fp_shift2 got=%b expected=0010", ia_wb_reserved); end
    tick();
    checks++;
    if (ia_wb_reserved !== 4'b0001) begin failures++; $display("FAIL fp_shift3 got=%b expected=0001", ia_wb_reserved); end
    req_v = 4'b0100;
    tick();
    checks++;
    if (ia_grant_valid !== 1'b0) begin failures++; $display("FAIL int_collision_denied got=%b expected=0", ia_grant_valid); end
    tick();
    checks++;
    if (ia_grant_oh !== 4'b0100) begin failures++; $display("FAIL int_after_collision got=%b expected=0100", ia_grant_oh); end
    req_v = '0;
  endtask

  task automatic test_rollback_free();
    do_reset();
    req_v = 4'b1000;
    req_l = 4'b1000;
    tick();
    tick();
    checks++;
    if (ia_grant_oh !== 4'b1000 || ia_grant_long !== 1'b1) begin
      failures++;
      $display("FAIL rb_fp_grant got oh=%b long=%b expected oh=1000 long=1", ia_grant_oh, ia_grant_long);
    end
    req_v = '0;
    req_l = '0;
    tick();
    tick();
    rb_en  = 1'b1;
    rb_idx = 2'd3;
    tick();
    rb_en = 1'b0;
    checks++;
    if (ia_wb_reserved !== 4'b0000) begin failures++; $display("FAIL rb_cleared got=%b expected=0000", ia_wb_reserved); end
    req_v = 4'b0001;
    tick();
    checks++;
    if (ia_grant_oh !== 4'b0001) begin failures++; $display("FAIL rb_int_no_stall got=%b expected=0001", ia_grant_oh); end
    req_v = '0;
  endtask

  task automatic test_rollback_same_cycle();
    do_reset();
    req_v = 4'b0010;
    req_l = 4'b0000;
    tick();
    tick();
    req_v  = 4'b0110;
    rb_en  = 1'b1;
    rb_idx = 2'd2;
    tick();
    checks++;
    if (ia_grant_oh !== 4'b0010) begin failures++; $display("FAIL rb_same_cycle got=%b expected=0010", ia_grant_oh); end
    rb_en = 1'b0;
    req_v = 4'b0100;
    tick();
    checks++;
    if (ia_grant_oh !== 4'b0100) begin failures++; $display("FAIL rb_released got=%b expected=0100", ia_grant_oh); end
    req_v = '0;
  endtask

  task automatic test_starvation();
    int waited;
    bit got;
    do_reset();
    req_v = 4'b1110;
    req_l = 4'b1110;
    repeat (7) tick();
    req_v  = 4'b1111;
    waited = 0;
    got    = 0;
    while (!got && waited < 40) begin
      tick();
      waited++;
      if (ia_grant_oh[0]) begin
        got   = 1;
        req_v = 4'b1110;
      end
    end
`ifdef FP_ISSUE_STARVATION_GUARD_EN
    checks++;
    if (!got || waited < 9 || waited > 13) begin
      failures++;
      $display("FAIL starve_guard got granted=%0d after=%0d cycles expected granted=1 within 9..13", got, waited);
    end
`else
    checks++;
    if (got) begin
      failures++;
      $display("FAIL starve_no_guard got granted after=%0d cycles expected never granted", waited);
    end
`endif
    req_v = '0;
    req_l = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_v = 4'b0110;
    req_l = 4'b0110;
    repeat (4) tick();
    checks++;
    if (ia_wb_reserved !== 4'b1110) begin failures++; $display("FAIL pre_reset_res got=%b expected=1110", ia_wb_reserved); end
    reset = 1'b1;
    #1;
    checks++;
    if (ia_wb_reserved !== 4'b0000 || ia_grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got res=%b v=%b expected res=0000 v=0", ia_wb_reserved, ia_grant_valid);
    end
    req_v = '0;
    req_l = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      req_v  = 4'($urandom_range(0, 15));
      req_l  = 4'($urandom_range(0, 15));
      rb_en  = ($urandom_range(0, 5) == 0);
      rb_idx = 2'($urandom_range(0, 3));
      tick();
    end
    req_v = '0;
    req_l = '0;
    rb_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_int();
    test_round_robin();
    test_fp_reserve();
    test_rollback_free();
    test_rollback_same_cycle();
    test_starvation();
    test_mid_reset();
    test_random();
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
